// File: rtl/lsu_axi_v2_if.sv
// Bus bundle for the load/store unit: pipeline request/response, AXI
// read/write channels and the D-cache port. The master modport is the LSU's
// own view; the slave modport is the view of everything around it.
interface lsu_axi_v2_if #(
    parameter int XLEN = 64
);
    localparam int STRBW = XLEN / 8;

    // Pipeline request from EX/LS
    logic             req_valid;
    logic             req_ready;
    logic             req_load;
    logic [XLEN-1:0]  req_addr;
    logic [XLEN-1:0]  req_wdata;
    logic [2:0]       req_func3;

    // Response to LS/WB
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_data;
    logic             resp_mmio;
    logic             resp_misalign;

    // AXI read channels
    logic             ar_valid;
    logic             ar_ready;
    logic [XLEN-1:0]  ar_addr;
    logic             r_valid;
    logic             r_ready;
    logic [XLEN-1:0]  r_data;

    // AXI write channels
    logic             aw_valid;
    logic             aw_ready;
    logic [XLEN-1:0]  aw_addr;
    logic             w_valid;
    logic             w_ready;
    logic [XLEN-1:0]  w_data;
    logic [STRBW-1:0] w_strb;
    logic             b_valid;
    logic             b_ready;

    // D-cache port
    logic             cache_valid;
    logic             cache_op;
    logic [XLEN-1:0]  cache_addr;
    logic [XLEN-1:0]  cache_wdata;
    logic [STRBW-1:0] cache_wmask;
    logic [XLEN-1:0]  cache_rdata;
    logic             cache_dataok;

    modport master (
        input  req_valid, req_load, req_addr, req_wdata, req_func3,
        output req_ready,
        output resp_valid, resp_data, resp_mmio, resp_misalign,
        input  resp_ready,
        output ar_valid, ar_addr,
        input  ar_ready,
        input  r_valid, r_data,
        output r_ready,
        output aw_valid, aw_addr,
        input  aw_ready,
        output w_valid, w_data, w_strb,
        input  w_ready,
        input  b_valid,
        output b_ready,
        output cache_valid, cache_op, cache_addr, cache_wdata, cache_wmask,
        input  cache_rdata, cache_dataok
    );

    modport slave (
        output req_valid, req_load, req_addr, req_wdata, req_func3,
        input  req_ready,
        input  resp_valid, resp_data, resp_mmio, resp_misalign,
        output resp_ready,
        input  ar_valid, ar_addr,
        output ar_ready,
        output r_valid, r_data,
        input  r_ready,
        input  aw_valid, aw_addr,
        output aw_ready,
        input  w_valid, w_data, w_strb,
        output w_ready,
        output b_valid,
        input  b_ready,
        input  cache_valid, cache_op, cache_addr, cache_wdata, cache_wmask,
        output cache_rdata, cache_dataok
    );
endinterface

// File: rtl/lsu_axi_v2.sv
// Load/store unit between EX/LS and LS/WB. One request in flight at a time;
// physical-memory addresses go to the D-cache, everything else is MMIO and
// goes out over AXI. Handles byte-lane alignment, misalignment detection,
// independent AW/W handshakes, the B channel and a registered response.
module lsu_axi_v2 #(
    parameter int          XLEN      = 64,
    parameter logic [63:0] PMEM_BASE = 64'h8000_0000,
    parameter logic [63:0] PMEM_SIZE = 64'h0800_0000
) (
    input logic          clock,
    input logic          reset,
    lsu_axi_v2_if.master bus
);
    localparam int STRBW = XLEN / 8;
    localparam int OFFW  = $clog2(STRBW);

    typedef enum logic [2:0] {
        IDLE,
        CACHE,
        AR,
        R,
        AWW,
        B,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic              reqLoad_q;
    logic [XLEN-1:0]   reqAddr_q;
    logic [XLEN-1:0]   reqWdata_q;
    logic [2:0]        reqFunc3_q;
    logic              awDone_q, awDone_d;
    logic              wDone_q, wDone_d;
    logic [XLEN-1:0]   respData_q;
    logic              respMmio_q;
    logic              respMisalign_q;

    logic              accept;
    logic              captureLoad;
    logic              reqMisalign;
    logic              reqPmem;
    logic [2:0]        lowMask;
    logic [64:0]       addrWide;
    logic [OFFW-1:0]   offset;
    logic [OFFW+2:0]   bitShift;
    logic [XLEN-1:0]   alignedAddr;
    logic [7:0]        sizeMask;
    logic [STRBW-1:0]  byteMask;
    logic [XLEN-1:0]   laneData;
    logic [XLEN-1:0]   loadRaw;
    logic [63:0]       raw64;
    logic [63:0]       ext64;
    logic [XLEN-1:0]   loadResult;

    assign accept = (state_q == IDLE) && bus.req_valid;

    // Classify the incoming request before it is latched: the low address
    // bits must be zero up to the access size, and the region check decides
    // between cache and MMIO. The region compare is one bit wider so that
    // BASE+SIZE cannot wrap.
    always_comb begin
        lowMask = 3'b000;
        case (bus.req_func3[1:0])
            2'd0:    lowMask = 3'b000;
            2'd1:    lowMask = 3'b001;
            2'd2:    lowMask = 3'b011;
            default: lowMask = 3'b111;
        endcase
        reqMisalign = |(bus.req_addr[2:0] & lowMask);
        addrWide    = {1'b0, 64'(bus.req_addr)};
        reqPmem     = (addrWide >= {1'b0, PMEM_BASE}) &&
                      (addrWide <  ({1'b0, PMEM_BASE} + {1'b0, PMEM_SIZE}));
    end

    // Byte-lane placement for the latched request: beat-aligned address,
    // strobes covering the access, store data shifted into its lanes.
    always_comb begin
        offset      = reqAddr_q[OFFW-1:0];
        bitShift    = {offset, 3'b000};
        alignedAddr = {reqAddr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
        sizeMask    = 8'h00;
        case (reqFunc3_q[1:0])
            2'd0:    sizeMask = 8'h01;
            2'd1:    sizeMask = 8'h03;
            2'd2:    sizeMask = 8'h0F;
            default: sizeMask = 8'hFF;
        endcase
        byteMask = STRBW'(sizeMask) << offset;
        laneData = reqWdata_q << bitShift;
    end

    // Load data path: pick the returning beat, shift the addressed bytes
    // down to bit 0 and sign- or zero-extend by access type. Extension is
    // done at 64 bits and then trimmed so one path serves both widths.
    always_comb begin
        loadRaw = ((state_q == R) ? bus.r_data : bus.cache_rdata) >> bitShift;
        raw64   = 64'(loadRaw);
        ext64   = raw64;
        case (reqFunc3_q)
            3'd0:    ext64 = {{56{raw64[7]}},  raw64[7:0]};
            3'd1:    ext64 = {{48{raw64[15]}}, raw64[15:0]};
            3'd2:    ext64 = {{32{raw64[31]}}, raw64[31:0]};
            3'd4:    ext64 = {56'd0, raw64[7:0]};
            3'd5:    ext64 = {48'd0, raw64[15:0]};
            3'd6:    ext64 = {32'd0, raw64[31:0]};
            default: ext64 = raw64;
        endcase
        loadResult = ext64[XLEN-1:0];
    end

    // State register plus the AW/W completion flags, which let the two
    // write handshakes finish independently in any order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            awDone_q <= 1'b0;
            wDone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            awDone_q <= awDone_d;
            wDone_q  <= wDone_d;
        end
    end

    // Next-state and handshake outputs. Every valid/ready is a pure function
    // of the state so nothing toggles outside the state that owns it, and
    // late r_valid/b_valid in other states are simply ignored.
    always_comb begin
        state_d         = state_q;
        awDone_d        = awDone_q;
        wDone_d         = wDone_q;
        captureLoad     = 1'b0;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.ar_valid    = 1'b0;
        bus.r_ready     = 1'b0;
        bus.aw_valid    = 1'b0;
        bus.w_valid     = 1'b0;
        bus.b_ready     = 1'b0;
        bus.cache_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    awDone_d = 1'b0;
                    wDone_d  = 1'b0;
                    if (reqMisalign)       state_d = DONE;
                    else if (reqPmem)      state_d = CACHE;
                    else if (bus.req_load) state_d = AR;
                    else                   state_d = AWW;
                end
            end
            CACHE: begin
                bus.cache_valid = 1'b1;
                if (bus.cache_dataok) begin
                    captureLoad = 1'b1;
                    state_d     = DONE;
                end
            end
            AR: begin
                bus.ar_valid = 1'b1;
                if (bus.ar_ready) state_d = R;
            end
            R: begin
                bus.r_ready = 1'b1;
                if (bus.r_valid) begin
                    captureLoad = 1'b1;
                    state_d     = DONE;
                end
            end
            AWW: begin
                bus.aw_valid = !awDone_q;
                bus.w_valid  = !wDone_q;
                awDone_d     = awDone_q | bus.aw_ready;
                wDone_d      = wDone_q | bus.w_ready;
                if (awDone_d && wDone_d) state_d = B;
            end
            B: begin
                bus.b_ready = 1'b1;
                if (bus.b_valid) state_d = DONE;
            end
            DONE: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch and registered response. The response fields are set
    // up at accept time (data cleared, flags decided) so they are already
    // stable when DONE is reached; only load data arrives later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reqLoad_q      <= 1'b0;
            reqAddr_q      <= '0;
            reqWdata_q     <= '0;
            reqFunc3_q     <= 3'd0;
            respData_q     <= '0;
            respMmio_q     <= 1'b0;
            respMisalign_q <= 1'b0;
        end else if (accept) begin
            reqLoad_q      <= bus.req_load;
            reqAddr_q      <= bus.req_addr;
            reqWdata_q     <= bus.req_wdata;
            reqFunc3_q     <= bus.req_func3;
            respData_q     <= '0;
            respMmio_q     <= !reqPmem;
            respMisalign_q <= reqMisalign;
        end else if (captureLoad && reqLoad_q) begin
            respData_q     <= loadResult;
        end
    end

    assign bus.resp_data     = respData_q;
    assign bus.resp_mmio     = respMmio_q;
    assign bus.resp_misalign = respMisalign_q;
    assign bus.ar_addr       = alignedAddr;
    assign bus.aw_addr       = alignedAddr;
    assign bus.w_data        = laneData;
    assign bus.w_strb        = byteMask;
    assign bus.cache_op      = !reqLoad_q;
    assign bus.cache_addr    = alignedAddr;
    assign bus.cache_wdata   = laneData;
    assign bus.cache_wmask   = byteMask;
endmodule

// File: tb/tb_lsu_axi_v2.sv
// Self-checking bench for lsu_axi_v2 (XLEN=64). Acts as pipeline, AXI slave
// and D-cache with configurable delays, and compares against a byte-level
// reference model of the load/store rules.
module tb_lsu_axi_v2;
    logic clock = 1'b0;
    logic reset = 1'b1;

    lsu_axi_v2_if #(.XLEN(64)) bus ();

    lsu_axi_v2 #(
        .XLEN      (64),
        .PMEM_BASE (64'h8000_0000),
        .PMEM_SIZE (64'h0800_0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    int          testCount = 0;
    int          failCount = 0;
    logic [63:0] obsRespData, obsAddr, obsWdata;
    logic [7:0]  obsStrb;
    logic        obsCacheOp;
    int          obsLatency;
    bit          sawBus, done;
    int          protoErr;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference: gather the addressed bytes one by one, then extend.
    function automatic logic [63:0] modelLoad(input logic [63:0] raw, input logic [63:0] addr, input logic [2:0] f3);
        int          off = int'(addr % 8);
        int          n   = 1 << (f3 % 4);
        logic [63:0] v   = 64'd0;
        for (int i = 0; i < n; i++)
            v |= ((raw >> (8 * (off + i))) & 64'hFF) << (8 * i);
        if (f3 < 4 && n < 8 && v[8*n-1])
            v |= ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    function automatic logic [7:0] modelStrb(input logic [63:0] addr, input logic [2:0] f3);
        logic [7:0] s = 8'd0;
        for (int i = 0; i < (1 << (f3 % 4)); i++)
            s |= 8'd1 << (int'(addr % 8) + i);
        return s;
    endfunction

    task automatic clearSlave();
        bus.cache_dataok = 1'b0;
        bus.ar_ready     = 1'b0;
        bus.r_valid      = 1'b0;
        bus.aw_ready     = 1'b0;
        bus.w_ready      = 1'b0;
        bus.b_valid      = 1'b0;
        bus.resp_ready   = 1'b0;
    endtask

    task automatic applyStimulus(input logic isLoad, input logic [63:0] addr, input logic [63:0] wdata, input logic [2:0] f3);
        bus.req_valid = 1'b1;
        bus.req_load  = isLoad;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_func3 = f3;
    endtask

    // One full transaction: issue, serve every channel with the given delays
    // (cycles of valid seen before the slave answers), then check the result.
    task automatic runTxn(input logic isLoad, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [2:0] f3, input logic [63:0] raw,
                          input int dly, input int awDly, input int wDly, input int respDly);
        int          cycle = 1;
        int          cacheCnt = 0, arCnt = 0, rCnt = 0, awCnt = 0, wCnt = 0, bCnt = 0, respCnt = 0;
        bit          awHs = 0, wHs = 0, awPend = 0, wPend = 0, respPend = 0, respSeen = 0;
        int          n = 1 << (f3 % 4);
        bit          expMis = (addr % n) != 0;
        bit          expPmem = (addr >= 64'h8000_0000) && (addr < 64'h8800_0000);
        int          expLat;
        logic [63:0] expData;
        logic [63:0] firstData = 64'd0;

        if (expMis)       expLat = 1;
        else if (expPmem) expLat = 2 + dly;
        else if (isLoad)  expLat = 3 + 2 * dly;
        else              expLat = 3 + ((awDly > wDly) ? awDly : wDly) + dly;
        expData = (isLoad && !expMis) ? modelLoad(raw, addr, f3) : 64'd0;

        done = 0; sawBus = 0; protoErr = 0; obsLatency = -1;
        obsAddr = 64'd0; obsWdata = 64'd0; obsStrb = 8'd0; obsCacheOp = 1'b0; obsRespData = 64'd0;

        @(negedge clock);
        checkOutput("req_ready_idle", bus.req_ready, 1);
        applyStimulus(isLoad, addr, wdata, f3);
        bus.r_data      = raw;
        bus.cache_rdata = raw;
        @(negedge clock);
        bus.req_valid = 1'b0;

        while (cycle <= 60) begin
            if (awPend) awHs = 1;
            if (wPend)  wHs  = 1;
            awPend = 0; wPend = 0;
            if (respPend) begin
                done = 1;
                break;
            end
            if (bus.req_ready) protoErr++;
            if (bus.cache_valid || bus.ar_valid || bus.aw_valid || bus.w_valid || bus.r_ready || bus.b_ready)
                sawBus = 1;
            if (bus.b_ready && !(awHs && wHs)) protoErr++;
            if (bus.aw_valid && awHs) protoErr++;
            if (bus.w_valid && wHs) protoErr++;
            clearSlave();
            if (bus.cache_valid) begin
                obsAddr = bus.cache_addr; obsWdata = bus.cache_wdata;
                obsStrb = bus.cache_wmask; obsCacheOp = bus.cache_op;
                if (cacheCnt >= dly) bus.cache_dataok = 1'b1;
                cacheCnt++;
            end
            if (bus.ar_valid) begin
                obsAddr = bus.ar_addr;
                if (arCnt >= dly) bus.ar_ready = 1'b1;
                arCnt++;
            end
            if (bus.r_ready) begin
                if (rCnt >= dly) bus.r_valid = 1'b1;
                rCnt++;
            end
            if (bus.aw_valid) begin
                obsAddr = bus.aw_addr;
                if (awCnt >= awDly) begin bus.aw_ready = 1'b1; awPend = 1; end
                awCnt++;
            end
            if (bus.w_valid) begin
                obsWdata = bus.w_data; obsStrb = bus.w_strb;
                if (wCnt >= wDly) begin bus.w_ready = 1'b1; wPend = 1; end
                wCnt++;
            end
            if (bus.b_ready) begin
                if (bCnt >= dly) bus.b_valid = 1'b1;
                bCnt++;
            end
            if (bus.resp_valid) begin
                if (!respSeen) begin
                    respSeen = 1; obsLatency = cycle; firstData = bus.resp_data;
                    obsRespData = bus.resp_data;
                    checkOutput("resp_mmio", bus.resp_mmio, !expPmem);
                    checkOutput("resp_misalign", bus.resp_misalign, expMis);
                end else if (bus.resp_data !== firstData) begin
                    protoErr++;
                end
                if (respCnt >= respDly) begin bus.resp_ready = 1'b1; respPend = 1; end
                respCnt++;
            end
            @(negedge clock);
            cycle++;
        end
        clearSlave();

        checkOutput("completed", done, 1);
        checkOutput("protocol_errors", protoErr, 0);
        checkOutput("latency", obsLatency, expLat);
        checkOutput("resp_data", obsRespData, expData);
        checkOutput("bus_activity", sawBus, !expMis);
        checkOutput("req_ready_after", bus.req_ready, 1);
        checkOutput("resp_valid_after", bus.resp_valid, 0);
        if (!expMis) checkOutput("beat_addr", obsAddr, addr & ~64'h7);
        if (!expMis && !isLoad) begin
            checkOutput("strobe", obsStrb, modelStrb(addr, f3));
            checkOutput("lane_data", obsWdata, wdata << (8 * (addr % 8)));
        end
        if (!expMis && expPmem) checkOutput("cache_op", obsCacheOp, !isLoad);
    endtask

    logic        rLoad;
    logic [2:0]  rF3;
    logic [63:0] rAddr, rData;
    int          waited;

    // Directed scenarios first, then a mid-transaction reset, then random traffic.
    initial begin
        bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_addr = 64'd0;
        bus.req_wdata = 64'd0; bus.req_func3 = 3'd0;
        bus.r_data = 64'd0; bus.cache_rdata = 64'd0;
        clearSlave();

        #1;
        checkOutput("reset_req_ready", bus.req_ready, 1);
        checkOutput("reset_valids", {bus.resp_valid, bus.ar_valid, bus.aw_valid, bus.w_valid,
                                     bus.r_ready, bus.b_ready, bus.cache_valid}, 0);
        checkOutput("reset_resp_data", bus.resp_data, 0);
        checkOutput("reset_flags", {bus.resp_mmio, bus.resp_misalign}, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        $display("[TB] LB from pmem with immediate dataok");
        runTxn(1'b1, 64'h8000_0003, 64'd0, 3'd0, 64'h0000_0000_80FF_0000, 0, 0, 0, 0);
        checkOutput("lb_value", obsRespData, 64'hFFFF_FFFF_FFFF_FF80);
        checkOutput("lb_cache_addr", obsAddr, 64'h8000_0000);

        $display("[TB] SH to MMIO with delayed aw_ready");
        runTxn(1'b0, 64'hA000_0006, 64'h1234, 3'd1, 64'd0, 0, 3, 0, 0);
        checkOutput("sh_strb", obsStrb, 8'hC0);
        checkOutput("sh_wdata", obsWdata, 64'h1234_0000_0000_0000);

        $display("[TB] SH to MMIO with delayed w_ready");
        runTxn(1'b0, 64'hA000_0012, 64'hFFFF_0000_0000_ABCD, 3'd1, 64'd0, 1, 0, 2, 1);

        $display("[TB] misaligned LW");
        runTxn(1'b1, 64'hA000_0002, 64'd0, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);

        $display("[TB] MMIO LWU with held-off resp_ready");
        runTxn(1'b1, 64'hA000_0004, 64'd0, 3'd6, 64'hDEAD_BEEF_0000_0000, 0, 0, 0, 4);
        checkOutput("lwu_value", obsRespData, 64'h0000_0000_DEAD_BEEF);

        $display("[TB] pmem region boundaries");
        runTxn(1'b1, 64'h87FF_FFF8, 64'd0, 3'd3, 64'h0123_4567_89AB_CDEF, 1, 0, 0, 0);
        runTxn(1'b1, 64'h8800_0000, 64'd0, 3'd2, 64'h0000_0000_8000_0001, 0, 0, 0, 0);
        runTxn(1'b1, 64'h7FFF_FFF8, 64'd0, 3'd5, 64'h0000_0000_0000_F00D, 0, 0, 0, 0);
        runTxn(1'b0, 64'h8000_0000, 64'hCAFE_F00D_1234_5678, 3'd3, 64'd0, 2, 0, 0, 0);

        $display("[TB] reset while waiting in R");
        @(negedge clock);
        applyStimulus(1'b1, 64'hA000_0010, 64'd0, 3'd2);
        @(negedge clock);
        bus.req_valid = 1'b0;
        waited = 0;
        while (!bus.r_ready && waited < 10) begin
            bus.ar_ready = bus.ar_valid;
            @(negedge clock);
            waited++;
        end
        bus.ar_ready = 1'b0;
        checkOutput("abort_reached_R", bus.r_ready, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_r_ready", bus.r_ready, 0);
        checkOutput("abort_resp_valid", bus.resp_valid, 0);
        checkOutput("abort_req_ready", bus.req_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        bus.r_valid = 1'b1;
        bus.b_valid = 1'b1;
        @(negedge clock);
        clearSlave();
        checkOutput("late_r_dropped", {bus.resp_valid, bus.r_ready, bus.b_ready}, 0);
        @(negedge clock);
        checkOutput("still_idle", bus.req_ready, 1);
        runTxn(1'b0, 64'h8000_1000, 64'h0011_2233_4455_6677, 3'd3, 64'd0, 0, 0, 0, 0);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 40; k++) begin
            rLoad = 1'($urandom_range(0, 1));
            rF3   = rLoad ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
            rAddr = ($urandom_range(0, 1) ? 64'h8000_0000 : 64'hA000_0000)
                    + 64'($urandom & 32'h00FF_FFF8) + 64'($urandom_range(0, 7));
            rData = {$urandom, $urandom};
            runTxn(rLoad, rAddr, {$urandom, $urandom}, rF3, rData,
                   $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
